// File: rtl/uart_pkg.sv
// Shared definitions for the UART tap: command encodings, error code and FSM states.
package uart_pkg;

   localparam logic [7:0] CMD_NOP   = 8'd0;
   localparam logic [7:0] CMD_READ  = 8'd1;
   localparam logic [7:0] CMD_WRITE = 8'd2;
   localparam logic [7:0] CMD_RESET = 8'd3;
   localparam logic [7:0] ERR_CODE  = 8'hFF;

   typedef enum logic [2:0] {
      IDLE, DECODE, RX_DATA, WR_REQ, RD_REQ, TX_HDR, TX_DATA, ERR
   } uart_state_t;

   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_tap_shift.sv
// Byte-wide shift register: LSB-first shift-in of write payload, parallel load and
// LSB-first shift-out of read data.
module uart_tap_shift #(
   parameter int WIDTH = 64
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             load,
   input  logic             shift_in,
   input  logic             shift_out,
   input  logic [WIDTH-1:0] load_data,
   input  logic [7:0]       byte_in,
   output logic [WIDTH-1:0] data,
   output logic [7:0]       byte_out
);

   localparam int SW = ((WIDTH + 7) / 8) * 8;

   logic [SW-1:0] sreg;

   // Bytes enter at the top so the first received byte ends up in bits [7:0].
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)          sreg <= '0;
      else if (load)      sreg <= SW'(load_data);
      else if (shift_in)  sreg <= (sreg >> 8) | (SW'(byte_in) << (SW - 8));
      else if (shift_out) sreg <= sreg >> 8;
   end

   assign data     = sreg[WIDTH-1:0];
   assign byte_out = sreg[7:0];

endmodule

// File: rtl/uart_tap_mc.sv
// UART-to-register tap: decodes command bytes from an RX FIFO into channel reads/writes.
// Optional payload timeout enabled by defining UART_TAP_TIMEOUT_EN.
module uart_tap_mc import uart_pkg::*; #(
   parameter int WIDTH   = 64,
   parameter int ADDR_W  = 5,
   parameter int NCH     = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   output logic              READ_O,
   input  logic [7:0]        DATA_REC_I,
   input  logic              RX_EMPTY_I,
   input  logic              CMD_REC_I,
   input  logic              TX_READY_I,
   output logic              WRITE_O,
   output logic [7:0]        DATA_SEND_O,
   output logic              SEND_COMMAND_O,
   output logic [7:0]        COMMAND_O,
   output logic [ADDR_W-1:0] WRITE_ADDRESS_O,
   output logic [WIDTH-1:0]  WRITE_DATA_O,
   output logic              WRITE_VALID_O,
   input  logic              WRITE_READY_I,
   output logic [ADDR_W-1:0] READ_ADDRESS_O,
   input  logic [WIDTH-1:0]  READ_DATA_I,
   input  logic              READ_VALID_I,
   output logic              READ_READY_O,
   output logic              HARD_RESET_O,
   output logic [7:0]        ERR_COUNT_O
);

   localparam int         NB   = nbytes(WIDTH);
   localparam logic [8:0] LAST = 9'(NB - 1);

   if (WIDTH < 8 || WIDTH > 256 || NCH < 1 || TIMEOUT < 1) begin : g_param_chk
      $error("uart_tap_mc: parameter out of range");
   end

   uart_state_t       state, nxt;
   logic [7:0]        cmd_q, err_q, cmd_f, tx_byte;
   logic [ADDR_W-1:0] addr_q;
   logic [8:0]        cnt;
   logic              pop, latch, sh_in, sh_out, ld, err_inc, cnt_clr, cnt_inc;
   logic              addr_ok, timeout;

   assign cmd_f   = 8'(cmd_q >> ADDR_W);
   assign addr_ok = 32'(cmd_q[ADDR_W-1:0]) < 32'(NCH);

`ifdef UART_TAP_TIMEOUT_EN
   localparam int          TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tcnt;

   // Counts consecutive empty cycles while waiting for payload.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)                             tcnt <= '0;
      else if (state == RX_DATA && RX_EMPTY_I) tcnt <= tcnt + 1'b1;
      else                                   tcnt <= '0;
   end
   assign timeout = (state == RX_DATA) && RX_EMPTY_I && (tcnt == TLAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state  <= IDLE;
         cmd_q  <= '0;
         addr_q <= '0;
         cnt    <= '0;
         err_q  <= '0;
      end else begin
         state <= nxt;
         if (latch)                cmd_q  <= DATA_REC_I;
         if (state == DECODE)      addr_q <= cmd_q[ADDR_W-1:0];
         if (cnt_clr)              cnt    <= '0;
         else if (cnt_inc)         cnt    <= cnt + 1'b1;
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 1'b1;
      end
   end

   always_comb begin
      nxt            = state;
      pop            = 1'b0;
      latch          = 1'b0;
      sh_in          = 1'b0;
      sh_out         = 1'b0;
      ld             = 1'b0;
      err_inc        = 1'b0;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      WRITE_O        = 1'b0;
      SEND_COMMAND_O = 1'b0;
      COMMAND_O      = 8'h00;
      WRITE_VALID_O  = 1'b0;
      READ_READY_O   = 1'b0;
      HARD_RESET_O   = 1'b0;
      case (state)
         IDLE: if (!RX_EMPTY_I) begin
            pop = 1'b1;
            if (CMD_REC_I) begin
               latch = 1'b1;
               nxt   = DECODE;
            end
         end
         DECODE: begin
            cnt_clr = 1'b1;
            if (!addr_ok) nxt = ERR;
            else case (cmd_f)
               CMD_NOP:   nxt = IDLE;
               CMD_READ:  nxt = TX_HDR;
               CMD_WRITE: nxt = RX_DATA;
               CMD_RESET: begin
                  HARD_RESET_O = 1'b1;
                  nxt          = IDLE;
               end
               default:   nxt = ERR;
            endcase
         end
         RX_DATA: if (!RX_EMPTY_I) begin
            pop = 1'b1;
            // A command byte mid-payload abandons the write and is decoded afresh.
            if (CMD_REC_I) begin
               latch   = 1'b1;
               err_inc = 1'b1;
               nxt     = DECODE;
            end else begin
               sh_in   = 1'b1;
               cnt_inc = 1'b1;
               if (cnt == LAST) nxt = WR_REQ;
            end
         end else if (timeout) begin
            nxt = ERR;
         end
         WR_REQ: begin
            WRITE_VALID_O = 1'b1;
            if (WRITE_READY_I) nxt = IDLE;
         end
         TX_HDR: begin
            SEND_COMMAND_O = 1'b1;
            COMMAND_O      = cmd_q;
            if (TX_READY_I) nxt = RD_REQ;
         end
         RD_REQ: begin
            READ_READY_O = 1'b1;
            if (READ_VALID_I) begin
               ld  = 1'b1;
               nxt = TX_DATA;
            end
         end
         TX_DATA: begin
            WRITE_O = 1'b1;
            if (TX_READY_I) begin
               sh_out  = 1'b1;
               cnt_inc = 1'b1;
               if (cnt == LAST) nxt = IDLE;
            end
         end
         ERR: begin
            SEND_COMMAND_O = 1'b1;
            COMMAND_O      = ERR_CODE;
            if (TX_READY_I) begin
               err_inc = 1'b1;
               nxt     = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   uart_tap_shift #(.WIDTH(WIDTH)) u_shift (
      .CLK_I     (CLK_I),
      .RST_I     (RST_I),
      .load      (ld),
      .shift_in  (sh_in),
      .shift_out (sh_out),
      .load_data (READ_DATA_I),
      .byte_in   (DATA_REC_I),
      .data      (WRITE_DATA_O),
      .byte_out  (tx_byte)
   );

   // RX_EMPTY_I can be low during reset; keep the pop strobe quiet then.
   assign READ_O          = pop & ~RST_I;
   assign DATA_SEND_O     = (state == TX_DATA) ? tx_byte : 8'h00;
   assign WRITE_ADDRESS_O = addr_q;
   assign READ_ADDRESS_O  = addr_q;
   assign ERR_COUNT_O     = err_q;

endmodule

// File: tb/tb_uart_tap_mc.sv
// Self-checking bench for uart_tap_mc (WIDTH=32, NCH=4, TIMEOUT=16); the timeout step
// follows UART_TAP_TIMEOUT_EN.
module tb_uart_tap_mc;

   localparam int WIDTH = 32, ADDR_W = 5, NCH = 4, TIMEOUT = 16, NB = 4;

   logic              CLK_I = 1'b0, RST_I = 1'b1;
   logic              READ_O, WRITE_O, SEND_COMMAND_O, WRITE_VALID_O, READ_READY_O, HARD_RESET_O;
   logic [7:0]        DATA_REC_I = 8'h00, DATA_SEND_O, COMMAND_O, ERR_COUNT_O;
   logic              RX_EMPTY_I = 1'b1, CMD_REC_I = 1'b0, TX_READY_I = 1'b0;
   logic              WRITE_READY_I = 1'b0, READ_VALID_I = 1'b0;
   logic [ADDR_W-1:0] WRITE_ADDRESS_O, READ_ADDRESS_O;
   logic [WIDTH-1:0]  WRITE_DATA_O, READ_DATA_I = '0;

   always #5 CLK_I = ~CLK_I;

   uart_tap_mc #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .READ_O(READ_O), .DATA_REC_I(DATA_REC_I),
      .RX_EMPTY_I(RX_EMPTY_I), .CMD_REC_I(CMD_REC_I), .TX_READY_I(TX_READY_I),
      .WRITE_O(WRITE_O), .DATA_SEND_O(DATA_SEND_O), .SEND_COMMAND_O(SEND_COMMAND_O),
      .COMMAND_O(COMMAND_O), .WRITE_ADDRESS_O(WRITE_ADDRESS_O), .WRITE_DATA_O(WRITE_DATA_O),
      .WRITE_VALID_O(WRITE_VALID_O), .WRITE_READY_I(WRITE_READY_I),
      .READ_ADDRESS_O(READ_ADDRESS_O), .READ_DATA_I(READ_DATA_I), .READ_VALID_I(READ_VALID_I),
      .READ_READY_O(READ_READY_O), .HARD_RESET_O(HARD_RESET_O), .ERR_COUNT_O(ERR_COUNT_O)
   );

   int n_cmp = 0, n_fail = 0, cyc = 0;
   int rd_hs = 0, hr_cnt = 0, both_cnt = 0, last_pop = -1, first_sc = -1, first_wo = -1;
   int exp_err = 0;
   logic [8:0]              rxq[$];
   logic [ADDR_W+WIDTH-1:0] wq[$];
   logic [7:0]              txq[$], cq[$];
   logic                    pop_pend = 1'b0;

   // RX FIFO model plus randomly stalling TX/channel partners.
   initial forever begin
      @(posedge CLK_I); #1;
      cyc++;
      if (pop_pend && rxq.size() > 0) rxq.delete(0);
      if (rxq.size() > 0) begin
         RX_EMPTY_I = 1'b0;
         CMD_REC_I  = rxq[0][8];
         DATA_REC_I = rxq[0][7:0];
      end else begin
         RX_EMPTY_I = 1'b1;
         CMD_REC_I  = 1'b0;
         DATA_REC_I = 8'h00;
      end
      TX_READY_I    = ($urandom_range(3) != 0);
      WRITE_READY_I = ($urandom_range(3) != 0);
      READ_VALID_I  = ($urandom_range(3) != 0);
   end

   // Record every completed handshake, sampled mid-cycle.
   initial forever begin
      @(negedge CLK_I);
      pop_pend = READ_O;
      if (!RST_I) begin
         if (READ_O) last_pop = cyc;
         if (WRITE_VALID_O && WRITE_READY_I) wq.push_back({WRITE_ADDRESS_O, WRITE_DATA_O});
         if (WRITE_O && TX_READY_I) txq.push_back(DATA_SEND_O);
         if (WRITE_O && first_wo < 0) first_wo = cyc;
         if (SEND_COMMAND_O) begin
            if (first_sc < 0) first_sc = cyc;
            if (TX_READY_I) cq.push_back(COMMAND_O);
         end
         if (READ_READY_O && READ_VALID_I) rd_hs++;
         if (HARD_RESET_O) hr_cnt++;
         if (WRITE_O && SEND_COMMAND_O) both_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b, input logic c);
      rxq.push_back({c, b});
   endtask

   task automatic clear();
      wq.delete(); txq.delete(); cq.delete();
      rd_hs = 0; hr_cnt = 0; first_sc = -1; first_wo = -1;
   endtask

   task automatic wait_ev(input string tag, input int nw, input int ntx, input int nc, input int nhr);
      int k = 0;
      while (!(rxq.size() == 0 && wq.size() >= nw && txq.size() >= ntx &&
               cq.size() >= nc && hr_cnt >= nhr) && k < 600) begin
         @(negedge CLK_I);
         k++;
      end
      chk({tag, "_done"}, 96'(k < 600), 96'(1));
      repeat (10) @(negedge CLK_I);
   endtask

   function automatic logic [95:0] outs();
      return 96'({READ_O, WRITE_O, DATA_SEND_O, SEND_COMMAND_O, COMMAND_O, WRITE_ADDRESS_O,
                  WRITE_DATA_O, WRITE_VALID_O, READ_ADDRESS_O, READ_READY_O, HARD_RESET_O,
                  ERR_COUNT_O});
   endfunction

   initial begin
      logic [WIDTH-1:0] d;
      logic [4:0]       a;
      int               k;

      repeat (3) @(negedge CLK_I);
      chk("reset_outputs", outs(), 96'(0));
      RST_I = 1'b0;

      // Directed write: junk byte is dropped, then addr 1 gets 0x12345678.
      clear();
      push(8'h9C, 0); push(8'h41, 1);
      push(8'h78, 0); push(8'h56, 0); push(8'h34, 0); push(8'h12, 0);
      wait_ev("wr32", 1, 0, 0, 0);
      chk("wr32_count", 96'(wq.size()), 96'(1));
      chk("wr32_addr_data", 96'(wq[0]), 96'({5'd1, 32'h12345678}));
      chk("wr32_err", 96'(ERR_COUNT_O), 96'(0));

      // Directed read: header echoes command, then data LSB first.
      clear();
      READ_DATA_I = 32'hCAFEF00D;
      push(8'h22, 1);
      wait_ev("rd", 0, 4, 1, 0);
      chk("rd_cmd", 96'({cq.size(), cq[0]}), 96'({32'd1, 8'h22}));
      chk("rd_bytes", 96'({txq.size(), txq[0], txq[1], txq[2], txq[3]}),
          96'({32'd4, 8'h0D, 8'hF0, 8'hFE, 8'hCA}));
      chk("rd_handshakes", 96'(rd_hs), 96'(1));
      chk("rd_addr", 96'(READ_ADDRESS_O), 96'(2));
      chk("rd_order", 96'(first_sc >= 0 && first_sc < first_wo), 96'(1));

      // Payload interrupted by a RESET command.
      clear();
      push(8'h41, 1); push(8'hAA, 0); push(8'hBB, 0); push(8'h60, 1);
      wait_ev("abort", 0, 0, 0, 1);
      exp_err++;
      chk("abort_no_write", 96'(wq.size()), 96'(0));
      chk("abort_err", 96'(ERR_COUNT_O), 96'(exp_err));
      chk("abort_pulse", 96'(hr_cnt), 96'(1));
      chk("abort_no_cmd", 96'(cq.size()), 96'(0));

      // Out-of-range addresses and an unknown command all answer 0xFF.
      clear();
      push(8'h27, 1);
      wait_ev("badaddr_rd", 0, 0, 1, 0);
      exp_err++;
      chk("badaddr_rd", 96'({cq[0], 32'(rd_hs), 32'(txq.size())}), 96'({8'hFF, 32'd0, 32'd0}));
      chk("badaddr_err", 96'(ERR_COUNT_O), 96'(exp_err));
      clear();
      push(8'h47, 1);
      wait_ev("badaddr_wr", 0, 0, 1, 0);
      exp_err++;
      chk("badaddr_wr", 96'({cq[0], 32'(wq.size())}), 96'({8'hFF, 32'd0}));
      clear();
      push(8'hA0, 1);
      wait_ev("badcmd", 0, 0, 1, 0);
      exp_err++;
      chk("badcmd", 96'({cq[0], ERR_COUNT_O}), 96'({8'hFF, 8'(exp_err)}));

      // NOP does nothing visible.
      clear();
      push(8'h01, 1);
      wait_ev("nop", 0, 0, 0, 0);
      chk("nop_quiet", 96'({32'(cq.size()), 32'(wq.size()), 32'(txq.size() + hr_cnt)}), 96'(0));

      // Silence during payload.
      clear();
      push(8'h41, 1); push(8'h11, 0);
`ifdef UART_TAP_TIMEOUT_EN
      wait_ev("timeout", 0, 0, 1, 0);
      exp_err++;
      chk("timeout_cmd", 96'(cq[0]), 96'(8'hFF));
      chk("timeout_latency", 96'(first_sc - last_pop), 96'(TIMEOUT + 1));
      chk("timeout_err", 96'(ERR_COUNT_O), 96'(exp_err));
`else
      repeat (100) @(negedge CLK_I);
      chk("no_timeout", 96'({32'(cq.size()), 32'(wq.size())}), 96'(0));
      push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
      wait_ev("late_payload", 1, 0, 0, 0);
      chk("late_payload", 96'(wq[0]), 96'({5'd1, 32'h44332211}));
`endif

      // Random reads and writes against a byte-level model.
      for (int t = 0; t < 24; t++) begin
         clear();
         a = 5'($urandom_range(NCH - 1));
         d = $urandom;
         for (int j = 0; j < int'($urandom_range(2)); j++) push(8'($urandom), 0);
         if ($urandom_range(1) == 1) begin
            push({3'd2, a}, 1);
            for (int b = 0; b < NB; b++) push(8'(d >> (8 * b)), 0);
            wait_ev("rnd_wr", 1, 0, 0, 0);
            chk("rnd_wr", 96'({32'(wq.size()), wq[0]}), 96'({32'd1, a, d}));
         end else begin
            READ_DATA_I = d;
            push({3'd1, a}, 1);
            wait_ev("rnd_rd", 0, NB, 1, 0);
            chk("rnd_rd_cmd", 96'(cq[0]), 96'({3'd1, a}));
            chk("rnd_rd_data", 96'({32'(txq.size()), txq[3], txq[2], txq[1], txq[0]}),
                96'({32'(NB), d}));
         end
      end
      chk("rnd_err_stable", 96'(ERR_COUNT_O), 96'(exp_err));

      // Reset while shifting out read data.
      clear();
      READ_DATA_I = 32'h89ABCDEF;
      push(8'h23, 1);
      k = 0;
      while (!WRITE_O && k < 600) begin
         @(negedge CLK_I);
         k++;
      end
      chk("reach_tx_data", 96'(WRITE_O), 96'(1));
      RST_I = 1'b1;
      #1;
      chk("rst_mid_outputs", outs(), 96'(0));
      repeat (3) @(negedge CLK_I);
      RST_I = 1'b0;
      clear();
      repeat (40) @(negedge CLK_I);
      chk("rst_dropped", 96'({32'(txq.size() + cq.size()), 32'(rd_hs), 32'(wq.size())}), 96'(0));
      chk("rst_err", 96'(ERR_COUNT_O), 96'(0));

      clear();
      push(8'h42, 1); push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 0);
      wait_ev("post_rst_wr", 1, 0, 0, 0);
      chk("post_rst_wr", 96'(wq[0]), 96'({5'd2, 32'h04030201}));
      chk("exclusive_tx", 96'(both_cnt), 96'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
